// File: rtl/systolic_array_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_pkg : shared types and helpers for systolic_array_seq        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int drain_cycles(input int dim);
    return 2 * dim - 2;
  endfunction

  // Clamp a sign-extended value into a signed range of the given width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_array_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_array_seq_if : A/B beat stream with valid/ready handshake    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface systolic_array_seq_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  logic                          in_vld;
  logic                          in_rdy;
  logic [DIM-1:0][BITS_AB-1:0]   A;
  logic [DIM-1:0][BITS_AB-1:0]   B;

  modport master (output in_vld, output A, output B, input  in_rdy);
  modport slave  (input  in_vld, input  A, input  B, output in_rdy);
endinterface
`default_nettype wire

// File: rtl/systolic_array_seq_tpumac_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tpumac_sat : one PE, A/B pass-through regs + saturating accumulator   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tpumac_sat
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [BITS_C-1:0]  cin,
  input  logic [BITS_AB-1:0] ain,
  input  logic [BITS_AB-1:0] bin,
  output logic [BITS_AB-1:0] aout,
  output logic [BITS_AB-1:0] bout,
  output logic [BITS_C-1:0]  acc,
  output logic               sat
);

  logic signed [BITS_C-1:0]    acc_q, acc_d;
  logic        [BITS_AB-1:0]   a_q, a_d, b_q, b_d;
  logic signed [2*BITS_AB-1:0] prod_w;
  logic signed [BITS_C:0]      sum_w;
  logic signed [63:0]          wide_w, clamp_w;

  // One guard bit above the accumulator catches overflow before clamping.
  assign prod_w  = $signed(ain) * $signed(bin);
  assign sum_w   = (BITS_C+1)'(acc_q) + (BITS_C+1)'(prod_w);
  assign wide_w  = 64'(sum_w);
  assign clamp_w = saturate(wide_w, BITS_C);

  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    if (clr) begin
      acc_d = '0;
    end else if (wr_en) begin
      acc_d = cin;
    end else if (en) begin
      acc_d = BITS_C'(clamp_w);
      a_d   = ain;
      b_d   = bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign sat  = en && !clr && !wr_en && (clamp_w != wide_w);
  assign acc  = acc_q;
  assign aout = a_q;
  assign bout = b_q;

endmodule
`default_nettype wire

// File: rtl/systolic_array_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_array_seq : self-sequencing DIM x DIM output-stationary MAC  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module systolic_array_seq
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int MAX_K   = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  systolic_array_seq_if.slave                 io,
  input  logic                                start,
  input  logic                                acc_mode,
  input  logic [$clog2(MAX_K+1)-1:0]          k_len,
  input  logic                                wr_en,
  input  logic [(DIM>1?$clog2(DIM):1)-1:0]    wr_row,
  input  logic [DIM-1:0][BITS_C-1:0]          Cin,
  input  logic [(DIM>1?$clog2(DIM):1)-1:0]    rd_row,
  output logic [DIM-1:0][BITS_C-1:0]          Cout,
  output logic                                busy,
  output logic                                done,
  output logic                                sat
);

  localparam int KW           = $clog2(MAX_K + 1);
  localparam int RW           = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DRAIN_CYCLES = drain_cycles(DIM);
  localparam int DCW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d, klen_q, klen_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            sat_q, sat_d;

  logic            start_go, clr_go, wr_go, accept, en, pe_sat_any;
  logic [BITS_AB-1:0] a_src [DIM];
  logic [BITS_AB-1:0] b_src [DIM];
  logic [BITS_AB-1:0] a_w   [DIM][DIM];
  logic [BITS_AB-1:0] b_w   [DIM][DIM];
  logic [BITS_C-1:0]  acc_w [DIM][DIM];
  logic               sat_w [DIM][DIM];

  assign start_go = start && (state_q == ST_IDLE);
  assign clr_go   = start_go && !acc_mode;
  assign wr_go    = wr_en && !start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept   = io.in_vld && (state_q == ST_FEED);
  assign en       = accept || (state_q == ST_DRAIN);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    klen_d      = klen_q;
    drain_cnt_d = drain_cnt_q;
    sat_d       = sat_q || pe_sat_any;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_FEED;
        beat_cnt_d = '0;
        klen_d     = (k_len == '0) ? KW'(1) : k_len;
        sat_d      = 1'b0;
      end
      ST_FEED: if (accept) begin
        beat_cnt_d = beat_cnt_q + KW'(1);
        if (beat_cnt_q == klen_q - KW'(1)) begin
          drain_cnt_d = '0;
          state_d     = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCW'(1);
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      klen_q      <= '0;
      drain_cnt_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      klen_q      <= klen_d;
      drain_cnt_q <= drain_cnt_d;
      sat_q       <= sat_d;
    end
  end

  // Row/column i of the operand stream is delayed by i stages before entering the grid.
  for (genvar i = 0; i < DIM; i++) begin : g_skew
    assign a_src[i] = (state_q == ST_DRAIN) ? '0 : io.A[i];
    assign b_src[i] = (state_q == ST_DRAIN) ? '0 : io.B[i];
    if (i == 0) begin : g_direct
      assign a_w[0][0] = a_src[0];
      assign b_w[0][0] = b_src[0];
    end else begin : g_delay
      logic [BITS_AB-1:0] ask_q [i];
      logic [BITS_AB-1:0] ask_d [i];
      logic [BITS_AB-1:0] bsk_q [i];
      logic [BITS_AB-1:0] bsk_d [i];
      always_comb begin
        ask_d = ask_q;
        bsk_d = bsk_q;
        if (en) begin
          ask_d[0] = a_src[i];
          bsk_d[0] = b_src[i];
          for (int j = 1; j < i; j++) begin
            ask_d[j] = ask_q[j-1];
            bsk_d[j] = bsk_q[j-1];
          end
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < i; j++) begin
            ask_q[j] <= '0;
            bsk_q[j] <= '0;
          end
        end else begin
          ask_q <= ask_d;
          bsk_q <= bsk_d;
        end
      end
      assign a_w[i][0] = ask_q[i-1];
      assign b_w[0][i] = bsk_q[i-1];
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [BITS_AB-1:0] a_out, b_out;
      logic               pe_wr;
      assign pe_wr = wr_go && (wr_row == RW'(r));
      tpumac_sat #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr_go),
        .wr_en (pe_wr),
        .cin   (Cin[c]),
        .ain   (a_w[r][c]),
        .bin   (b_w[r][c]),
        .aout  (a_out),
        .bout  (b_out),
        .acc   (acc_w[r][c]),
        .sat   (sat_w[r][c])
      );
      if (c < DIM - 1) begin : g_a_link
        assign a_w[r][c+1] = a_out;
      end else begin : g_a_edge
        logic [BITS_AB-1:0] a_out_unused;
        assign a_out_unused = a_out;
      end
      if (r < DIM - 1) begin : g_b_link
        assign b_w[r+1][c] = b_out;
      end else begin : g_b_edge
        logic [BITS_AB-1:0] b_out_unused;
        assign b_out_unused = b_out;
      end
    end
  end

  always_comb begin
    pe_sat_any = 1'b0;
    Cout       = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        pe_sat_any = pe_sat_any | sat_w[r][c];
        if (rd_row == RW'(r)) Cout[c] = acc_w[r][c];
      end
    end
  end

  assign io.in_rdy = (state_q == ST_FEED);
  assign busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign sat       = sat_q;

endmodule
`default_nettype wire
